// File: rtl/mult4_arbiter_if.sv
// mult4_arbiter_if: requester/consumer bundle around the shared mult4; op_count only with MULT4_ARB_STATS_EN
interface mult4_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [3:0]        prod_lo;
  logic [3:0]        prod_hi;
`ifdef MULT4_ARB_STATS_EN
  logic [15:0]       op_count;
  modport master (output req_valid, req_a, req_b, resp_ready,
                  input  req_ready, resp_valid, resp_id, prod_lo, prod_hi, op_count);
  modport slave  (input  req_valid, req_a, req_b, resp_ready,
                  output req_ready, resp_valid, resp_id, prod_lo, prod_hi, op_count);
`else
  modport master (output req_valid, req_a, req_b, resp_ready,
                  input  req_ready, resp_valid, resp_id, prod_lo, prod_hi);
  modport slave  (input  req_valid, req_a, req_b, resp_ready,
                  output req_ready, resp_valid, resp_id, prod_lo, prod_hi);
`endif
endinterface

// File: rtl/mult4_arbiter.sv
// mult4_arbiter: round-robin share of one registered 4x4 multiplier; MULT4_ARB_STATS_EN adds op_count
module mult4_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mult4_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
  state_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_win, w_idx;
  logic           w_any, w_take;
  logic [3:0]     r_a, r_b;
  logic [7:0]     r_prod;
  // round-robin pick: scan downward from the far end so the nearest valid at/after the pointer wins
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k >= NREQ) ? IDW'(int'(r_ptr) + k - NREQ) : IDW'(int'(r_ptr) + k);
      if (bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end
  // next state and the combinational one-hot grant, only offered in IDLE
  always_comb begin
    w_take        = (r_state == IDLE) && w_any;
    w_next        = (r_state == IDLE) ? (w_any ? MUL : IDLE) :
                    (r_state == MUL)  ? RESP :
                    (bus.resp_ready ? IDLE : RESP);
    bus.req_ready = w_take ? (NREQ'(1) << w_win) : '0;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // operand capture on grant, product register in MUL; outputs hold while RESP waits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
    end else begin
      if (w_take) begin
        r_a   <= bus.req_a[4*w_win +: 4];
        r_b   <= bus.req_b[4*w_win +: 4];
        r_id  <= w_win;
        r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (r_state == MUL) r_prod <= 8'(r_a) * 8'(r_b);
    end
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_id    = r_id;
  assign bus.prod_lo    = r_prod[3:0];
  assign bus.prod_hi    = r_prod[7:4];
`ifdef MULT4_ARB_STATS_EN
  logic [15:0] r_cnt;
  // completed response handshakes, wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                  r_cnt <= '0;
    else if (bus.resp_valid && bus.resp_ready)   r_cnt <= r_cnt + 16'd1;
  assign bus.op_count = r_cnt;
`endif
endmodule

// File: tb/tb_mult4_arbiter.sv
// tb_mult4_arbiter: directed vectors for the shared mult4 arbiter
module tb_mult4_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  mult4_arbiter_if #(.NREQ(2), .IDW(1)) bus ();
  mult4_arbiter #(.NREQ(2), .IDW(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic wait_ready();
    int n = 0;
    #1;
    while (bus.req_ready == '0 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_ready", 32'(bus.req_ready != '0), 1);
  endtask
  task automatic wait_resp();
    int n = 0;
    @(negedge clk);
    #1;
    while (!bus.resp_valid && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_resp", 32'(bus.resp_valid), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("idle_ready", 32'(bus.req_ready), 0);
    chk("idle_rvalid", 32'(bus.resp_valid), 0);
    chk("idle_prod", 32'({bus.prod_hi, bus.prod_lo}), 0);
    chk("idle_id", 32'(bus.resp_id), 0);
    bus.req_valid = 2'b01;
    bus.req_a     = 8'h03;
    bus.req_b     = 8'h07;
    wait_ready();
    chk("t2_grant", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("t2_mul_ready", 32'(bus.req_ready), 0);
    chk("t2_mul_rvalid", 32'(bus.resp_valid), 0);
    wait_resp();
    chk("t2_hi", 32'(bus.prod_hi), 1);
    chk("t2_lo", 32'(bus.prod_lo), 5);
    chk("t2_id", 32'(bus.resp_id), 0);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("t2_done", 32'(bus.resp_valid), 0);
    bus.req_valid = 2'b10;
    bus.req_a     = 8'hF0;
    bus.req_b     = 8'hF0;
    wait_ready();
    chk("t3_grant", 32'(bus.req_ready), 32'b10);
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp();
    repeat (4) begin
      chk("t3_hold_valid", 32'(bus.resp_valid), 1);
      chk("t3_hold_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'hE1);
      chk("t3_hold_id", 32'(bus.resp_id), 1);
      @(negedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    chk("t3_done", 32'(bus.resp_valid), 0);
    bus.req_a      = 8'h18;
    bus.req_b      = 8'h92;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      chk("t4_grant", 32'(bus.req_ready), (i % 2) ? 32'b10 : 32'b01);
      wait_resp();
      chk("t4_id", 32'(bus.resp_id), 32'(i % 2));
      chk("t4_prod", 32'({bus.prod_hi, bus.prod_lo}), (i % 2) ? 32'h09 : 32'h10);
    end
    bus.req_valid = '0;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 2'b01;
    bus.req_a      = 8'h02;
    bus.req_b      = 8'h03;
    wait_ready();
    chk("t5_grant", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 32'(bus.resp_valid), 0);
    chk("t5_rst_prod", 32'({bus.prod_hi, bus.prod_lo}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("t5_no_stale", 32'(bus.resp_valid), 0);
    end
    bus.req_valid = 2'b11;
    bus.req_a     = 8'h46;
    bus.req_b     = 8'h57;
    wait_ready();
    chk("t5_ptr_zero", 32'(bus.req_ready), 32'b01);
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp();
    chk("t5_id", 32'(bus.resp_id), 0);
    chk("t5_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'h2A);
    rst_n = 1'b0;
    #1;
    chk("t5_resp_rst_valid", 32'(bus.resp_valid), 0);
    chk("t5_resp_rst_prod", 32'({bus.prod_hi, bus.prod_lo}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_b      = 8'h05;
    for (int a = 0; a < 16; a++) begin
      bus.req_a     = {4'h0, 4'(a)};
      bus.req_valid = 2'b01;
      wait_ready();
      chk("t6_grant", 32'(bus.req_ready), 32'b01);
      @(negedge clk);
      bus.req_valid = '0;
      bus.req_a     = {4'h0, ~4'(a)};
      wait_resp();
      chk("t6_prod", 32'({bus.prod_hi, bus.prod_lo}), 32'(5 * a));
      chk("t6_id", 32'(bus.resp_id), 0);
    end
    @(negedge clk);
    #1;
    chk("t6_end_rvalid", 32'(bus.resp_valid), 0);
`ifdef MULT4_ARB_STATS_EN
    chk("t6_op_count", 32'(bus.op_count), 16);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
